circle_plot: RTL

Downstream stage of the `circle` distance generator: consumes its (xa, ya) octant-step distances and turns each step into absolute pixel coordinates around a centre, either as a 4-point outline or as horizontal filled spans. It drives `circle`'s `start` and `oe`, absorbs its `valid` and `done`, and presents one pixel per enabled cycle to the framebuffer writer with an `oe` stall. Sits between `circle` and the pixel-write arbiter in the gfx pipeline.

---
 rtl/circle_plot.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/circle_plot.sv
// Turns octant-step distances from the circle generator into absolute pixels
// around a centre, as a 4-point outline or as filled horizontal spans.
module circle_plot #(
  parameter int CORDW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    oe,
  input  logic                    fill,
  input  logic signed [CORDW-1:0] x0,
  input  logic signed [CORDW-1:0] y0,
  input  logic signed [CORDW-1:0] c_xa,
  input  logic signed [CORDW-1:0] c_ya,
  input  logic                    c_valid,
  input  logic                    c_done,
  output logic                    c_start,
  output logic                    c_oe,
  output logic signed [CORDW-1:0] x,
  output logic signed [CORDW-1:0] y,
  output logic                    drawing,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    Q0     = 4'd2,
    Q1     = 4'd3,
    Q2     = 4'd4,
    Q3     = 4'd5,
    SPAN_T = 4'd6,
    SPAN_B = 4'd7,
    FIN    = 4'd8
  } state_t;

  state_t state, next_state;

  logic signed [CORDW-1:0] xc, yc;
  logic signed [CORDW-1:0] xa, ya;
  logic signed [CORDW-1:0] sx;
  logic signed [CORDW-1:0] span_last;
  logic signed [CORDW-1:0] px, py;
  logic                    fill_mode;
  logic                    src_done;
  logic                    emit;
  logic                    span_end;

  // Spans run from x0+xa up to x0-xa inclusive; compare with wrap-safe equality.
  assign span_last = xc - xa;
  assign span_end  = (sx == span_last);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, source handshake and the pixel belonging to the current state.
  always_comb begin
    next_state = state;
    c_oe       = 1'b0;
    emit       = 1'b0;
    px         = xc;
    py         = yc;
    case (state)
      IDLE: begin
        if (start) next_state = FETCH;
        else       next_state = IDLE;
      end
      FETCH: begin
        if (c_valid) begin
          c_oe = 1'b1;
          if (fill_mode) next_state = SPAN_T;
          else           next_state = Q0;
        end else if (src_done) begin
          next_state = FIN;
        end else begin
          next_state = FETCH;
        end
      end
      Q0: begin
        emit = 1'b1;
        px   = xc - xa;
        py   = yc + ya;
        if (oe) next_state = Q1;
        else    next_state = Q0;
      end
      Q1: begin
        emit = 1'b1;
        px   = xc - ya;
        py   = yc - xa;
        if (oe) next_state = Q2;
        else    next_state = Q1;
      end
      Q2: begin
        emit = 1'b1;
        px   = xc + xa;
        py   = yc - ya;
        if (oe) next_state = Q3;
        else    next_state = Q2;
      end
      Q3: begin
        emit = 1'b1;
        px   = xc + ya;
        py   = yc + xa;
        if (oe) next_state = FETCH;
        else    next_state = Q3;
      end
      SPAN_T: begin
        emit = 1'b1;
        px   = sx;
        py   = yc - ya;
        if (oe && span_end) next_state = SPAN_B;
        else                next_state = SPAN_T;
      end
      SPAN_B: begin
        emit = 1'b1;
        px   = sx;
        py   = yc + ya;
        if (oe && span_end) next_state = FETCH;
        else                next_state = SPAN_B;
      end
      FIN: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: latched operands, span cursor, registered pixel and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      xc        <= '0;
      yc        <= '0;
      xa        <= '0;
      ya        <= '0;
      sx        <= '0;
      fill_mode <= 1'b0;
      src_done  <= 1'b0;
      x         <= '0;
      y         <= '0;
      drawing   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      c_start   <= 1'b0;
    end else begin
      c_start <= 1'b0;
      done    <= 1'b0;
      drawing <= 1'b0;

      if (state == IDLE && start) begin
        xc        <= x0;
        yc        <= y0;
        fill_mode <= fill;
        c_start   <= 1'b1;
        busy      <= 1'b1;
      end

      // A done from the source can land mid-span; remember it until FETCH runs dry.
      if (state == IDLE) begin
        if (start) src_done <= 1'b0;
      end else if (c_done) begin
        src_done <= 1'b1;
      end

      if (c_oe) begin
        xa <= c_xa;
        ya <= c_ya;
        sx <= xc + c_xa;
      end

      if (emit && oe) begin
        x       <= px;
        y       <= py;
        drawing <= 1'b1;
        if (state == SPAN_T || state == SPAN_B) begin
          if (span_end) sx <= xc + xa;
          else          sx <= sx + CORDW'(1);
        end
      end

      if (state == FIN) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule
